beam_steer_sequencer: RTL and testbench
=======================================

// Module: beam_steer_sequencer
// PURPOSE
//  Sequences the beamformer's per-channel delay registers. Holds a table of delay sets (one per
//  beam direction), serially shifts the selected set into the delay-register load port
//  (select/data/shift) aligned to a WS frame boundary, dwells a programmable number of frames,
//  then advances to the next beam. Sits between configuration logic and the delay-register port.
// PARAMETERS
//  NUM_CHANNELS  3  delay registers loaded per beam (1..8; select port fixed at 3 bits)
//  DELAY_BITS    4  bits per delay value (= log2 of channel buffer depth)
//  NUM_BEAMS     4  table entries (beam directions); power of two
//  DWELL_W       8  width of dwell_frames
// PORTS
//  clk           in   1                         system clock, all logic on posedge
//  rst_n         in   1                         asynchronous active-low reset
//  ena           in   1                         sequencer enable
//  start         in   1                         one-cycle pulse: begin sequencing from beam 0
//  ws            in   1                         word-select from frame timing (clk domain)
//  dwell_frames  in   DWELL_W                   frames to hold each beam (0 treated as 1)
//  tbl_we        in   1                         table write strobe
//  tbl_beam      in   clog2(NUM_BEAMS)          table write beam index
//  tbl_ch        in   3                         table write channel index
//  tbl_data      in   DELAY_BITS                table write delay value
//  dly_sel       out  3                         delay-register select
//  dly_data      out  1                         serial delay bit, MSB first
//  dly_shift     out  1                         shift strobe; dly_sel/dly_data valid when high
//  beam_idx      out  clog2(NUM_BEAMS)          beam currently loaded/being loaded
//  busy          out  1                         high in any state except IDLE
//  load_done     out  1                         one-cycle pulse after last bit of a beam shifted
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counters 0, all table entries 0.
//  Table: tbl_we writes entry[tbl_beam][tbl_ch] next edge in any state; tbl_ch>=NUM_CHANNELS ignored.
//  Frame edge: fe = ws & ~ws_q (registered ws); first cycle after reset ws_q=0.
//  FSM states: IDLE, WAIT_FRAME, LOAD, DWELL.
//   IDLE: start & ena -> beam_idx=0, WAIT_FRAME. start while busy ignored.
//   WAIT_FRAME: fe -> latch whole entry[beam_idx] into shift shadow, LOAD.
//   LOAD: per channel c=0..NUM_CHANNELS-1, per bit b=DELAY_BITS-1..0, two cycles:
//     phase A: dly_sel=c, dly_data=bit, dly_shift=0; phase B: same values, dly_shift=1.
//     Load takes exactly 2*DELAY_BITS*NUM_CHANNELS cycles; on last phase B exit -> load_done=1
//     next cycle, then DWELL (or IDLE if ena=0). Table writes during LOAD affect next load only.
//     dly_sel/dly_data hold last values outside LOAD; dly_shift=0 outside phase B.
//   DWELL: frame counter cleared on entry; increments on fe; when count reaches
//     max(dwell_frames,1) on an fe: beam_idx <= beam_idx+1 (wraps NUM_BEAMS-1 -> 0), latch
//     new entry, LOAD in the same cycle (no extra frame wait).
//   ena=0: from WAIT_FRAME or DWELL -> IDLE next cycle; in LOAD the load completes first.
//   dwell_frames sampled on each fe in DWELL (changes take effect immediately).
//  Reset mid-LOAD: outputs drop to 0 immediately; partially shifted register contents are not
//  the sequencer's concern (downstream is reset by the same rst_n).
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> all outputs 0 at once, FSM IDLE, busy=0.
//  2 Table beam0={ch0=4'hA,ch1=4'h3,ch2=4'hF}, start, ws edge -> 24 cycles, 12 shift pulses:
//    sel 0 bits 1,0,1,0; sel 1 bits 0,0,1,1; sel 2 bits 1,1,1,1; load_done 1 cycle after.
//  3 dwell_frames=2, NUM_BEAMS=4 -> loads start on frame edges 1,3,5,7,9; beam_idx 0,1,2,3,0.
//  4 dwell_frames=0 -> behaves as 1: new load on every ws rising edge.
//  5 Write entry[beam_idx][1]=4'h5 during LOAD -> current shift uses old value, next load uses 5.
//  6 ena=0 mid-LOAD -> all 24 cycles complete, load_done, then IDLE; start during busy ignored.

Source files
------------

// File: rtl/beam_steer_sequencer_if.sv
// beam_steer_sequencer_if: table-write and delay-register load port bundle for the beam steer sequencer
interface beam_steer_sequencer_if #(
  parameter int DELAY_BITS = 4,
  parameter int NUM_BEAMS = 4,
  localparam int BW = NUM_BEAMS > 1 ? $clog2(NUM_BEAMS) : 1
);
  logic tbl_we;
  logic [BW-1:0] tbl_beam;
  logic [2:0] tbl_ch;
  logic [DELAY_BITS-1:0] tbl_data;
  logic [2:0] dly_sel;
  logic dly_data;
  logic dly_shift;
  modport master (
    input tbl_we, tbl_beam, tbl_ch, tbl_data,
    output dly_sel, dly_data, dly_shift
  );
  modport slave (
    output tbl_we, tbl_beam, tbl_ch, tbl_data,
    input dly_sel, dly_data, dly_shift
  );
endinterface

// File: rtl/beam_steer_sequencer.sv
// beam_steer_sequencer: shifts per-beam delay sets into the delay-register port on frame edges, dwelling between beams
module beam_steer_sequencer #(
  parameter int NUM_CHANNELS = 3,
  parameter int DELAY_BITS = 4,
  parameter int NUM_BEAMS = 4,
  parameter int DWELL_W = 8,
  localparam int BW = NUM_BEAMS > 1 ? $clog2(NUM_BEAMS) : 1
) (
  input logic clk,
  input logic rst_n,
  input logic ena,
  input logic start,
  input logic ws,
  input logic [DWELL_W-1:0] dwell_frames,
  beam_steer_sequencer_if.master bus,
  output logic [BW-1:0] beam_idx,
  output logic busy,
  output logic load_done
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int BTW = DELAY_BITS > 1 ? $clog2(DELAY_BITS) : 1;
  localparam int DW1 = DWELL_W + 1;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, LOAD, DWELL} state_t;
  state_t state_q, state_d;
  logic [DELAY_BITS-1:0] tbl_q [NUM_BEAMS][NUM_CHANNELS];
  logic [DELAY_BITS-1:0] tbl_d [NUM_BEAMS][NUM_CHANNELS];
  logic [DELAY_BITS-1:0] shadow_q [NUM_CHANNELS];
  logic [DELAY_BITS-1:0] shadow_d [NUM_CHANNELS];
  logic [CW-1:0] ch_q, ch_d;
  logic [BTW-1:0] bit_q, bit_d;
  logic [DWELL_W-1:0] fc_q, fc_d;
  logic [BW-1:0] beam_q, beam_d;
  logic [2:0] sel_q, sel_d;
  logic data_q, data_d, shift_q, shift_d, busy_q, busy_d, done_q, done_d, ws_q;
  logic fe, latch, last;
  logic [DW1-1:0] fc_inc, dwell_eff;
  assign fe = ws & ~ws_q;
  assign fc_inc = {1'b0, fc_q} + 1'b1;
  assign dwell_eff = (dwell_frames == '0) ? DW1'(1) : {1'b0, dwell_frames};
  assign last = (ch_q == CW'(NUM_CHANNELS - 1)) && (bit_q == '0);
  always_comb begin
    state_d = state_q;
    tbl_d = tbl_q;
    shadow_d = shadow_q;
    ch_d = ch_q;
    bit_d = bit_q;
    fc_d = fc_q;
    beam_d = beam_q;
    sel_d = sel_q;
    data_d = data_q;
    shift_d = 1'b0;
    done_d = 1'b0;
    latch = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = (start && ena) ? WAIT_FRAME : IDLE;
        beam_d = (start && ena) ? '0 : beam_q;
      end
      WAIT_FRAME: begin
        state_d = ena ? WAIT_FRAME : IDLE;
        latch = ena && fe;
      end
      LOAD:
        if (!shift_q) shift_d = 1'b1;
        else if (last) begin
          done_d = 1'b1;
          fc_d = '0;
          state_d = ena ? DWELL : IDLE;
        end else begin
          ch_d = (bit_q == '0) ? ch_q + 1'b1 : ch_q;
          bit_d = (bit_q == '0) ? BTW'(DELAY_BITS - 1) : bit_q - 1'b1;
          sel_d = 3'(ch_d);
          data_d = shadow_q[ch_d][bit_d];
        end
      DWELL:
        if (!ena) state_d = IDLE;
        else if (fe) begin
          latch = fc_inc >= dwell_eff;
          beam_d = latch ? beam_q + 1'b1 : beam_q;
          fc_d = fc_inc[DWELL_W-1:0];
        end
      default: state_d = IDLE;
    endcase
    if (latch) begin
      state_d = LOAD;
      shadow_d = tbl_q[beam_d];
      ch_d = '0;
      bit_d = BTW'(DELAY_BITS - 1);
      sel_d = '0;
      data_d = tbl_q[beam_d][0][DELAY_BITS-1];
    end
    if (bus.tbl_we && ({1'b0, bus.tbl_ch} < 4'(NUM_CHANNELS))) tbl_d[bus.tbl_beam][bus.tbl_ch[CW-1:0]] = bus.tbl_data;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tbl_q <= '{default: '0};
      shadow_q <= '{default: '0};
      ch_q <= '0;
      bit_q <= '0;
      fc_q <= '0;
      beam_q <= '0;
      sel_q <= '0;
      data_q <= 1'b0;
      shift_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ws_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q <= tbl_d;
      shadow_q <= shadow_d;
      ch_q <= ch_d;
      bit_q <= bit_d;
      fc_q <= fc_d;
      beam_q <= beam_d;
      sel_q <= sel_d;
      data_q <= data_d;
      shift_q <= shift_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ws_q <= ws;
    end
  end
  assign bus.dly_sel = sel_q;
  assign bus.dly_data = data_q;
  assign bus.dly_shift = shift_q;
  assign beam_idx = beam_q;
  assign busy = busy_q;
  assign load_done = done_q;
endmodule

// File: tb/tb_beam_steer_sequencer.sv
// tb_beam_steer_sequencer: directed frames against a queue-based reference model plus literal expectations
module tb_beam_steer_sequencer;
  localparam int NC = 3;
  localparam int DB = 4;
  localparam int NB = 4;
  localparam int DW = 8;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_LOAD = 2;
  localparam int M_DWELL = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic start = 1'b0;
  logic ws = 1'b0;
  logic [DW-1:0] dwell_frames = '0;
  logic [1:0] beam_idx;
  logic busy, load_done;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_count = 0;
  beam_steer_sequencer_if #(.DELAY_BITS(DB), .NUM_BEAMS(NB)) bsi ();
  beam_steer_sequencer #(.NUM_CHANNELS(NC), .DELAY_BITS(DB), .NUM_BEAMS(NB), .DWELL_W(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .ws(ws),
    .dwell_frames(dwell_frames),
    .bus(bsi),
    .beam_idx(beam_idx),
    .busy(busy),
    .load_done(load_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  logic [DB-1:0] m_tbl [NB][NC];
  int m_state, m_beam, m_frames, m_sel, m_data, m_shift;
  bit m_done, m_ws, m_fe;
  logic [4:0] m_q[$];
  task automatic m_begin_load();
    m_q.delete();
    for (int c = 0; c < NC; c++)
      for (int b = DB - 1; b >= 0; b--) begin
        m_q.push_back({3'(c), m_tbl[m_beam][c][b], 1'b0});
        m_q.push_back({3'(c), m_tbl[m_beam][c][b], 1'b1});
      end
    m_state = M_LOAD;
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_beam = 0;
      m_frames = 0;
      m_sel = 0;
      m_data = 0;
      m_shift = 0;
      m_done = 0;
      m_ws = 0;
      m_q.delete();
      for (int b = 0; b < NB; b++)
        for (int c = 0; c < NC; c++) m_tbl[b][c] = '0;
    end else begin
      m_fe = ws && !m_ws;
      m_ws = ws;
      m_done = 0;
      case (m_state)
        M_IDLE:
          if (start && ena) begin
            m_state = M_WAIT;
            m_beam = 0;
          end
        M_WAIT:
          if (!ena) m_state = M_IDLE;
          else if (m_fe) m_begin_load();
        M_LOAD: begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_done = 1;
            m_frames = 0;
            m_state = ena ? M_DWELL : M_IDLE;
          end
        end
        default:
          if (!ena) m_state = M_IDLE;
          else if (m_fe) begin
            m_frames++;
            if (m_frames >= ((dwell_frames == 0) ? 1 : int'(dwell_frames))) begin
              m_beam = (m_beam + 1) % NB;
              m_begin_load();
            end
          end
      endcase
      if (bsi.tbl_we && int'(bsi.tbl_ch) < NC) m_tbl[int'(bsi.tbl_beam)][int'(bsi.tbl_ch)] = bsi.tbl_data;
      if (m_state == M_LOAD) begin
        m_sel = int'(m_q[0][4:2]);
        m_data = int'(m_q[0][1]);
        m_shift = int'(m_q[0][0]);
      end else m_shift = 0;
    end
    #1;
    chk("busy", int'(busy), int'(m_state != M_IDLE));
    chk("beam_idx", int'(beam_idx), m_beam);
    chk("load_done", int'(load_done), int'(m_done));
    chk("dly_shift", int'(bsi.dly_shift), m_shift);
    chk("dly_sel", int'(bsi.dly_sel), m_sel);
    chk("dly_data", int'(bsi.dly_data), m_data);
  end
  int p_sel[$], p_bit[$], p_cyc[$], d_beam[$], d_fe[$], d_cyc[$];
  always @(negedge clk)
    if (rst_n) begin
      if (bsi.dly_shift) begin
        p_sel.push_back(int'(bsi.dly_sel));
        p_bit.push_back(int'(bsi.dly_data));
        p_cyc.push_back(cyc);
      end
      if (load_done) begin
        d_beam.push_back(int'(beam_idx));
        d_fe.push_back(fe_count);
        d_cyc.push_back(cyc);
      end
    end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic tbl_write(input int b, input int c, input int d);
    @(negedge clk);
    bsi.tbl_we = 1'b1;
    bsi.tbl_beam = 2'(b);
    bsi.tbl_ch = 3'(c);
    bsi.tbl_data = 4'(d);
    @(negedge clk);
    bsi.tbl_we = 1'b0;
  endtask
  task automatic clear_rec();
    p_sel.delete();
    p_bit.delete();
    p_cyc.delete();
    d_beam.delete();
    d_fe.delete();
    d_cyc.delete();
  endtask
  task automatic frame(input int act);
    @(negedge clk);
    ws = 1'b1;
    fe_count++;
    if (act == 1) begin
      tick(6);
      bsi.tbl_we = 1'b1;
      bsi.tbl_beam = 2'd0;
      bsi.tbl_ch = 3'd1;
      bsi.tbl_data = 4'h5;
      tick(1);
      bsi.tbl_we = 1'b0;
      tick(25);
    end else if (act == 2) begin
      tick(4);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      ena = 1'b0;
      tick(23);
    end else if (act == 3) begin
      tick(10);
      @(posedge clk);
      #2;
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_beam", int'(beam_idx), 1);
      chk("pre_rst_sel", int'(bsi.dly_sel), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_beam", int'(beam_idx), 0);
      chk("rst_sel", int'(bsi.dly_sel), 0);
      chk("rst_shift", int'(bsi.dly_shift), 0);
      chk("rst_data", int'(bsi.dly_data), 0);
      chk("rst_done", int'(load_done), 0);
      tick(2);
      rst_n = 1'b1;
      tick(19);
    end else tick(32);
    ws = 1'b0;
    tick(32);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bsi.tbl_we = 1'b0;
    bsi.tbl_beam = '0;
    bsi.tbl_ch = '0;
    bsi.tbl_data = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("init_busy", int'(busy), 0);
    chk("init_beam", int'(beam_idx), 0);
    chk("init_shift", int'(bsi.dly_shift), 0);
    tbl_write(0, 0, 'hA);
    tbl_write(0, 1, 'h3);
    tbl_write(0, 2, 'hF);
    tbl_write(0, 3, 'h7);
    tbl_write(1, 0, 'h1);
    tbl_write(1, 1, 'h2);
    tbl_write(1, 2, 'h4);
    tbl_write(2, 0, 'h7);
    tbl_write(2, 1, 'h8);
    tbl_write(2, 2, 'h9);
    tbl_write(3, 0, 'hC);
    tbl_write(3, 1, 'h0);
    tbl_write(3, 2, 'h6);
    dwell_frames = 8'd2;
    ena = 1'b1;
    pulse_start();
    tick(2);
    chk("wait_busy", int'(busy), 1);
    clear_rec();
    frame(0);
    begin
      int exp_sel[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
      int exp_bit[12] = '{1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      chk("load0_pulses", p_sel.size(), 12);
      for (int i = 0; i < 12; i++) begin
        chk("load0_sel", at(p_sel, i), exp_sel[i]);
        chk("load0_bit", at(p_bit, i), exp_bit[i]);
      end
      chk("load0_span", at(p_cyc, 11) - at(p_cyc, 0), 22);
      chk("load0_done_lat", at(d_cyc, 0) - at(p_cyc, 0), 23);
    end
    repeat (3) frame(0);
    pulse_start();
    tick(1);
    chk("start_busy_ignored", int'(beam_idx), 1);
    repeat (5) frame(0);
    begin
      int exp_b[5] = '{0, 1, 2, 3, 0};
      int exp_f[5] = '{1, 3, 5, 7, 9};
      chk("dwell2_loads", d_beam.size(), 5);
      for (int i = 0; i < 5; i++) begin
        chk("dwell2_beam", at(d_beam, i), exp_b[i]);
        chk("dwell2_fe", at(d_fe, i), exp_f[i]);
      end
    end
    dwell_frames = 8'd0;
    clear_rec();
    repeat (3) frame(0);
    begin
      int exp_b[3] = '{1, 2, 3};
      int exp_f[3] = '{10, 11, 12};
      chk("dwell0_loads", d_beam.size(), 3);
      for (int i = 0; i < 3; i++) begin
        chk("dwell0_beam", at(d_beam, i), exp_b[i]);
        chk("dwell0_fe", at(d_fe, i), exp_f[i]);
      end
    end
    clear_rec();
    frame(1);
    begin
      int exp_old[4] = '{0, 0, 1, 1};
      for (int i = 0; i < 4; i++) chk("old_ch1_bit", at(p_bit, 4 + i), exp_old[i]);
    end
    repeat (3) frame(0);
    clear_rec();
    frame(0);
    begin
      int exp_new[4] = '{0, 1, 0, 1};
      chk("new_load_beam", at(d_beam, 0), 0);
      for (int i = 0; i < 4; i++) chk("new_ch1_bit", at(p_bit, 4 + i), exp_new[i]);
    end
    clear_rec();
    frame(2);
    chk("ena_off_pulses", p_sel.size(), 12);
    chk("ena_off_dones", d_beam.size(), 1);
    chk("ena_off_idle", int'(busy), 0);
    clear_rec();
    frame(0);
    chk("idle_no_pulses", p_sel.size(), 0);
    chk("idle_busy", int'(busy), 0);
    ena = 1'b1;
    pulse_start();
    frame(0);
    frame(3);
    pulse_start();
    clear_rec();
    frame(0);
    begin
      int s = 0;
      foreach (p_bit[i]) s += p_bit[i];
      chk("post_rst_pulses", p_sel.size(), 12);
      chk("post_rst_table_zero", s, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
